// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the BCD counter / digit scan controller.
package seg_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  typedef enum logic {BLANK, DRIVE} scan_state_t;
  typedef logic [3:0] bcd_t;
endpackage

// File: rtl/bcd_decade.sv
// bcd_decade: one 0..9 decade with synchronous clear and terminal-count output.
module bcd_decade
  import seg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t value,
  output logic wrap
);
  assign wrap = value == BCD_MAX;
  always_ff @(posedge clk)
    value <= (rst || clr) ? '0 : inc ? (wrap ? '0 : value + 4'd1) : value;
endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: cascaded BCD decade counter with blank-separated multiplexed digit scan.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int SCAN_DIV   = 1000,
  parameter int LZB        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cnt_en,
  input  logic                    cnt_clr,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    carry_out,
  output logic [4*NUM_DIGITS-1:0] count_bcd
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [TW-1:0] tick_cnt;
  logic tick;
  bcd_t dec [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] inc, wrap, blank;
  logic lz;
  scan_state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [SW-1:0] scan_cnt, scan_cnt_n;
  logic last;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    tick_cnt <= (rst || cnt_clr || tick) ? '0 : tick_cnt + TW'(1);
  // Clear wins over a coincident tick, so it also suppresses the carry.
  assign inc[0] = tick & cnt_en & ~cnt_clr;
  genvar i;
  generate
    for (i = 0; i < NUM_DIGITS; i++) begin : g_dec
      if (i > 0) begin : g_inc
        assign inc[i] = inc[i-1] & wrap[i-1];
      end
      bcd_decade u_dec (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (inc[i]),
        .value (dec[i]),
        .wrap  (wrap[i])
      );
      assign count_bcd[4*i +: 4] = dec[i];
    end
  endgenerate
  always_ff @(posedge clk)
    carry_out <= !rst && inc[0] && (&wrap);
  // A digit is a leading zero when it and every higher decade are zero.
  always_comb begin
    lz = 1'b1;
    blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz = lz && dec[k] == 4'd0;
      blank[k] = LZB != 0 && k > 0 && lz;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      idx <= '0;
      scan_cnt <= '0;
      digit_bcd <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      scan_cnt <= scan_cnt_n;
      digit_bcd <= dec[idx];
    end
  end
  always_comb begin
    last = scan_cnt == SW'(SCAN_DIV - 1);
    state_n = state == BLANK ? DRIVE : last ? BLANK : DRIVE;
    scan_cnt_n = (state == DRIVE && !last) ? scan_cnt + SW'(1) : '0;
    idx_n = !(state == DRIVE && last) ? idx : idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1);
    digit_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++)
      digit_sel[k] = !(state == DRIVE && idx == IW'(k) && !blank[k]);
  end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed checks of counting, carry, clear, reset and scan/blanking.
module tb_seg_scan_controller;
  logic clk = 1'b0, rst = 1'b1, cnt_en = 1'b0, cnt_clr = 1'b0;
  logic [3:0] digit_bcd, digit_sel;
  logic carry_out;
  logic [15:0] count_bcd;
  int vec = 0, miss = 0, ncyc = 0;
  always #5 clk = ~clk;
  seg_scan_controller #(.NUM_DIGITS(4), .TICK_DIV(2), .SCAN_DIV(3), .LZB(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .digit_bcd (digit_bcd),
    .digit_sel (digit_sel),
    .carry_out (carry_out),
    .count_bcd (count_bcd)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      ncyc++;
    end
  endtask
  function automatic logic [3:0] exp_sel(input int p, input logic [15:0] cnt);
    int slot;
    logic [15:0] hi;
    logic [3:0] one;
    slot = (p % 16) / 4;
    hi = cnt >> (4 * slot);
    one = 4'b0001 << slot;
    if (p % 4 == 0 || (slot > 0 && hi == 16'h0)) return 4'hf;
    return ~one;
  endfunction
  initial begin
    int p;
    logic [15:0] shv;
    step(2);
    rst = 1'b0;
    cnt_en = 1'b1;
    step(246);
    chk("count_before_reset", count_bcd, 16'h0123);
    rst = 1'b1;
    step(3);
    chk("rst_count", count_bcd, 16'h0);
    chk("rst_sel", digit_sel, 4'hf);
    chk("rst_carry", carry_out, 1'b0);
    chk("rst_bcd", digit_bcd, 4'h0);
    rst = 1'b0;
    ncyc = 0;
    chk("blank_after_rst", digit_sel, 4'hf);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("nibble0_range", {31'b0, count_bcd[3:0] <= 4'd9}, 32'd1);
      if (k == 1) chk("first_drive_sel", digit_sel, 4'b1110);
      if (k == 18) chk("count_9", count_bcd, 16'h0009);
    end
    chk("count_20cyc", count_bcd, 16'h0010);
    step(19978);
    chk("count_9999", count_bcd, 16'h9999);
    chk("carry_pre", carry_out, 1'b0);
    step(1);
    chk("carry_pre_tick", carry_out, 1'b0);
    step(1);
    chk("wrap_count", count_bcd, 16'h0);
    chk("wrap_carry", carry_out, 1'b1);
    step(1);
    chk("carry_one_cycle", carry_out, 1'b0);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_count", count_bcd, 16'h0);
    step(84);
    chk("count_42", count_bcd, 16'h0042);
    step(1);
    chk("count_42_tick", count_bcd, 16'h0042);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    chk("clr_on_tick_count", count_bcd, 16'h0);
    chk("clr_on_tick_carry", carry_out, 1'b0);
    step(1);
    chk("after_clr_hold", count_bcd, 16'h0);
    step(1);
    chk("after_clr_first_inc", count_bcd, 16'h0001);
    step(608);
    chk("count_305", count_bcd, 16'h0305);
    cnt_en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      p = ncyc % 16;
      chk("scan_sel", digit_sel, exp_sel(p, 16'h0305));
      shv = 16'h0305 >> (4 * (p / 4));
      if (p % 4 != 0) chk("scan_bcd", digit_bcd, shv[3:0]);
      chk("hold_count", count_bcd, 16'h0305);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
